lcd_hex_writer: RTL and testbench

//  Consumes the 32-bit display word from the LCD display-select stage and renders it as 8 upper-case
//  hex digits on line 1 of an HD44780-compatible character LCD. Uses the 8-bit write-only interface.

---
 rtl/lcd_hex_writer.sv | 161 ++++++++++++++++
 tb/tb_lcd_hex_writer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/lcd_hex_writer.sv
// Renders a 32-bit word as 8 upper-case hex digits on line 1 of an HD44780 LCD (8-bit, write-only).
// Build option LCD_HEX_PREFIX_EN: prefix the digits with "0x" (10 characters instead of 8).
module lcd_hex_writer #(
   parameter int INIT_WAIT_CYC = 750000,
   parameter int EN_PULSE_CYC  = 25,
   parameter int CMD_WAIT_CYC  = 2000,
   parameter int CLR_WAIT_CYC  = 82000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] value,
   output logic [7:0]  lcd_data,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic        lcd_en,
   output logic        lcd_on,
   output logic        ready,
   output logic        busy
);

   localparam int MAX_AB  = (INIT_WAIT_CYC > EN_PULSE_CYC) ? INIT_WAIT_CYC : EN_PULSE_CYC;
   localparam int MAX_CD  = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
   localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW      = $clog2(MAX_CYC + 1);

`ifdef LCD_HEX_PREFIX_EN
   localparam logic [3:0] DIG_BASE = 4'd3;
`else
   localparam logic [3:0] DIG_BASE = 4'd1;
`endif
   localparam logic [3:0] REF_LAST = DIG_BASE + 4'd7;

   typedef enum logic [1:0] {INIT_WAIT, INIT_CMD, IDLE, REFRESH} state_t;
   typedef enum logic [1:0] {SETUP, PULSE, HOLD} phase_t;

   state_t        state;
   phase_t        phase;
   logic [CW-1:0] cnt;
   logic [3:0]    idx;
   logic [31:0]   shown;
   logic [CW-1:0] hold_last;
   logic          last_byte;
   logic [8:0]    next_byte;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction

   function automatic logic [8:0] init_byte(input logic [3:0] i);
      case (i)
         4'd0:    return {1'b0, 8'h38};
         4'd1:    return {1'b0, 8'h0C};
         4'd2:    return {1'b0, 8'h01};
         default: return {1'b0, 8'h06};
      endcase
   endfunction

   // Byte i of a refresh as {rs, data}: DDRAM address, optional "0x", then nibbles MSB first.
   function automatic logic [8:0] refresh_byte(input logic [3:0] i, input logic [31:0] word);
      logic [8:0] b;
      b = {1'b0, 8'h80};
`ifdef LCD_HEX_PREFIX_EN
      if (i == 4'd1) b = {1'b1, 8'h30};
      if (i == 4'd2) b = {1'b1, 8'h78};
`endif
      for (int k = 0; k < 8; k++)
         if (i == DIG_BASE + 4'(k)) b = {1'b1, hex_char(word[31-4*k -: 4])};
      return b;
   endfunction

   // The clear command needs the long settle time; the byte on the bus identifies it.
   assign hold_last = (!lcd_rs && lcd_data == 8'h01) ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
   assign last_byte = (state == INIT_CMD) ? (idx == 4'd3) : (idx == REF_LAST);
   assign next_byte = (state == INIT_CMD) ? init_byte(idx + 4'd1) : refresh_byte(idx + 4'd1, shown);

   assign lcd_rw = 1'b0;
   assign lcd_on = 1'b1;

   // One byte engine serves both init and refresh: setup, enable pulse, then hold while the LCD settles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= INIT_WAIT;
         phase    <= SETUP;
         cnt      <= '0;
         idx      <= '0;
         shown    <= '0;
         lcd_data <= '0;
         lcd_rs   <= 1'b0;
         lcd_en   <= 1'b0;
         ready    <= 1'b0;
         busy     <= 1'b1;
      end else begin
         case (state)
            INIT_WAIT: begin
               if (cnt == CW'(INIT_WAIT_CYC - 1)) begin
                  state              <= INIT_CMD;
                  phase              <= SETUP;
                  cnt                <= '0;
                  idx                <= '0;
                  {lcd_rs, lcd_data} <= init_byte(4'd0);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            INIT_CMD, REFRESH: begin
               case (phase)
                  SETUP: begin
                     lcd_en <= 1'b1;
                     phase  <= PULSE;
                     cnt    <= '0;
                  end
                  PULSE: begin
                     if (cnt == CW'(EN_PULSE_CYC - 1)) begin
                        lcd_en <= 1'b0;
                        phase  <= HOLD;
                        cnt    <= '0;
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end
                  HOLD: begin
                     if (cnt == hold_last) begin
                        cnt   <= '0;
                        phase <= SETUP;
                        if (!last_byte) begin
                           idx                <= idx + 4'd1;
                           {lcd_rs, lcd_data} <= next_byte;
                        end else if (state == INIT_CMD) begin
                           ready              <= 1'b1;
                           state              <= REFRESH;
                           idx                <= '0;
                           shown              <= value;
                           {lcd_rs, lcd_data} <= refresh_byte(4'd0, value);
                        end else begin
                           state <= IDLE;
                           busy  <= 1'b0;
                        end
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end
                  default: phase <= SETUP;
               endcase
            end
            IDLE: begin
               if (value != shown) begin
                  state              <= REFRESH;
                  busy               <= 1'b1;
                  shown              <= value;
                  idx                <= '0;
                  phase              <= SETUP;
                  cnt                <= '0;
                  {lcd_rs, lcd_data} <= refresh_byte(4'd0, value);
               end
            end
            default: state <= INIT_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Directed bench for lcd_hex_writer with scaled timing; expects the "0x" prefix when LCD_HEX_PREFIX_EN is defined.
module tb_lcd_hex_writer;

   logic        clk;
   logic        rst;
   logic [31:0] value;
   logic [7:0]  lcd_data;
   logic        lcd_rs;
   logic        lcd_rw;
   logic        lcd_en;
   logic        lcd_on;
   logic        ready;
   logic        busy;

   int checkCount = 0;
   int failCount  = 0;

   lcd_hex_writer #(
      .INIT_WAIT_CYC(20),
      .EN_PULSE_CYC (2),
      .CMD_WAIT_CYC (4),
      .CLR_WAIT_CYC (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .value   (value),
      .lcd_data(lcd_data),
      .lcd_rs  (lcd_rs),
      .lcd_rw  (lcd_rw),
      .lcd_en  (lcd_en),
      .lcd_on  (lcd_on),
      .ready   (ready),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] newValue);
      value = newValue;
   endtask

   // Cycle-by-cycle check of one byte write: 1 setup, 2 enable, then hold cycles.
   task automatic expectByte(input string tag, input logic rs, input logic [7:0] data, input int hold,
                             input int changeCycle, input logic [31:0] newValue);
      logic en;
      for (int c = 0; c < 3 + hold; c++) begin
         @(negedge clk);
         en = (c == 1 || c == 2);
         checkOutput($sformatf("%s_c%0d", tag, c), 32'({busy, lcd_en, lcd_rs, lcd_data}),
                     32'({1'b1, en, rs, data}));
         if (c == changeCycle) applyStimulus(newValue);
      end
   endtask

   task automatic expectRefresh(input string tag, input logic [63:0] chars, input int changeDigit,
                                input logic [31:0] newValue);
      expectByte({tag, "_addr"}, 1'b0, 8'h80, 4, -1, 32'h0);
`ifdef LCD_HEX_PREFIX_EN
      expectByte({tag, "_pfx0"}, 1'b1, 8'h30, 4, -1, 32'h0);
      expectByte({tag, "_pfxx"}, 1'b1, 8'h78, 4, -1, 32'h0);
`endif
      for (int d = 0; d < 8; d++)
         expectByte($sformatf("%s_dig%0d", tag, d), 1'b1, chars[63-8*d -: 8], 4,
                    (d == changeDigit) ? 2 : -1, newValue);
      @(negedge clk);
      checkOutput({tag, "_done"}, 32'({busy, lcd_en, lcd_on, lcd_rw}), 32'({1'b0, 1'b0, 1'b1, 1'b0}));
   endtask

   // Called at a negedge with reset still asserted; releases it and follows the init sequence.
   task automatic runInit(input string tag);
      checkOutput({tag, "_reset"}, 32'({lcd_on, lcd_rw, ready, busy, lcd_en, lcd_rs, lcd_data}),
                  32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));
      rst = 1'b0;
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         checkOutput($sformatf("%s_wait%0d", tag, i), 32'({busy, ready, lcd_en}), 32'({1'b1, 1'b0, 1'b0}));
      end
      expectByte({tag, "_fnset"}, 1'b0, 8'h38, 4, -1, 32'h0);
      expectByte({tag, "_dispon"}, 1'b0, 8'h0C, 4, -1, 32'h0);
      expectByte({tag, "_clear"}, 1'b0, 8'h01, 8, -1, 32'h0);
      checkOutput({tag, "_notready"}, 32'(ready), 32'(0));
      expectByte({tag, "_entry"}, 1'b0, 8'h06, 4, -1, 32'h0);
   endtask

   initial begin
      logic [7:0] firstChar;
      logic       quietBad;
      rst   = 1'b1;
      value = 32'h0;
      repeat (3) @(negedge clk);

      $display("[TB] power-on init and first refresh");
      runInit("init1");
      expectRefresh("ref0", 64'h30303030_30303030, -1, 32'h0);
      checkOutput("ready_after_init", 32'(ready), 32'(1));

      $display("[TB] refresh on value change");
      applyStimulus(32'h1234ABCF);
      expectRefresh("ref1234", 64'h31323334_41424346, -1, 32'h0);

      $display("[TB] value change mid-refresh");
      applyStimulus(32'hDEADBEEF);
      expectRefresh("refdead", 64'h44454144_42454546, 3, 32'h0000_0001);
      expectRefresh("ref0001", 64'h30303030_30303031, -1, 32'h0);

      $display("[TB] idle with constant value");
      quietBad = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (lcd_en !== 1'b0 || busy !== 1'b0) quietBad = 1'b1;
      end
      checkOutput("idle_quiet", 32'(quietBad), 32'(0));

      $display("[TB] reset during enable pulse");
      applyStimulus(32'hCAFE0000);
`ifdef LCD_HEX_PREFIX_EN
      firstChar = 8'h30;
`else
      firstChar = 8'h43;
`endif
      expectByte("rst_addr", 1'b0, 8'h80, 4, -1, 32'h0);
      @(negedge clk);
      checkOutput("rst_setup", 32'({busy, lcd_en, lcd_rs, lcd_data}), 32'({1'b1, 1'b0, 1'b1, firstChar}));
      @(negedge clk);
      checkOutput("rst_pulse", 32'({busy, lcd_en, lcd_rs, lcd_data}), 32'({1'b1, 1'b1, 1'b1, firstChar}));
      rst = 1'b1;
      #1;
      checkOutput("rst_immediate", 32'({lcd_en, ready, busy, lcd_rs, lcd_data}),
                  32'({1'b0, 1'b0, 1'b1, 1'b0, 8'h00}));
      @(negedge clk);
      runInit("init2");
      expectRefresh("refcafe", 64'h43414645_30303030, -1, 32'h0);
      checkOutput("ready_after_reinit", 32'(ready), 32'(1));

`ifdef LCD_HEX_PREFIX_EN
      $display("[TB] prefixed refresh of all-F word");
      applyStimulus(32'hFFFFFFFF);
      expectRefresh("refffff", 64'h46464646_46464646, -1, 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
